// File: rtl/ir_pkg.sv
// Shared constants and helpers for the instruction queue.
package ir_pkg;

    localparam int unsigned IR_WIDTH = 16;
    localparam int unsigned IR_DEPTH = 4;

    // NOP doubles as the reset/empty value driven to decode
    localparam logic [63:0] IR_NOP = '0;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ir_queue_mem.sv
// DEPTH x WIDTH storage: one clocked write port, one asynchronous read port, no reset.
module ir_queue_mem #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ir_queue.sv
// Instruction register queue between fetch and decode, with branch flush.
// Optional same-cycle empty-queue bypass enabled by IR_QUEUE_BYPASS_EN.
module ir_queue
    import ir_pkg::*;
#(
    parameter int unsigned WIDTH = IR_WIDTH,
    parameter int unsigned DEPTH = IR_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          ins,
    input  logic                      ins_valid,
    output logic                      ins_ready,
    input  logic                      flush,
    output logic [WIDTH-1:0]          ir_out,
    output logic                      ir_valid,
    input  logic                      ir_ready,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] rd_data;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             bypass_take;
    logic             mem_we;
    logic             rd_adv;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign ins_ready = !full;

    // Head presentation; empty queue shows NOP unless fetch bypasses straight through
    always_comb begin
        ir_valid = !empty;
        ir_out   = empty ? WIDTH'(IR_NOP) : rd_data;
`ifdef IR_QUEUE_BYPASS_EN
        if (empty && ins_valid && !flush) begin
            ir_valid = 1'b1;
            ir_out   = ins;
        end
`endif
    end

    assign push = ins_valid && ins_ready && !flush;
    assign pop  = ir_valid && ir_ready && !flush;

`ifdef IR_QUEUE_BYPASS_EN
    assign bypass_take = empty && push && ir_ready;
`else
    assign bypass_take = 1'b0;
`endif

    // An instruction consumed on bypass never touches storage or pointers
    assign mem_we = push && !bypass_take;
    assign rd_adv = pop && !bypass_take;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (mem_we) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({mem_we, rd_adv})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    ir_queue_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (ins),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_ir_queue.sv
// Self-checking bench for ir_queue: directed steps plus random traffic against a queue model.
module tb_ir_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ins;
    logic        ins_valid;
    logic        ins_ready;
    logic        flush;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic        ir_ready;
    logic [2:0]  count;

    logic [31:0] w_ins;
    logic        w_ins_valid;
    logic        w_ins_ready;
    logic [31:0] w_ir_out;
    logic        w_ir_valid;
    logic        w_ir_ready;
    logic [3:0]  w_count;

    int total = 0;
    int bad   = 0;
    logic [15:0] q [$];

    always #5 clk = ~clk;

    ir_queue dut (
        .clk       (clk),
        .rst       (rst),
        .ins       (ins),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .flush     (flush),
        .ir_out    (ir_out),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .count     (count)
    );

    ir_queue #(.WIDTH(32), .DEPTH(8)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .ins       (w_ins),
        .ins_valid (w_ins_valid),
        .ins_ready (w_ins_ready),
        .flush     (1'b0),
        .ir_out    (w_ir_out),
        .ir_valid  (w_ir_valid),
        .ir_ready  (w_ir_ready),
        .count     (w_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check the narrow DUT before the edge, then advance the model
    task automatic cycle(input logic iv, input logic [15:0] d, input logic rdy, input logic fl);
        logic        byp;
        logic        acc;
        logic [15:0] exp_out;
        ins_valid = iv;
        ins       = d;
        ir_ready  = rdy;
        flush     = fl;
        @(negedge clk);
        byp = 1'b0;
`ifdef IR_QUEUE_BYPASS_EN
        byp = (q.size() == 0) && iv && !fl;
`endif
        exp_out = 16'h0000;
        if (byp) exp_out = d;
        else if (q.size() > 0) exp_out = q[0];
        chk("count", 64'(count), 64'(q.size()));
        chk("ins_ready", 64'(ins_ready), 64'(q.size() < DEPTH));
        chk("ir_valid", 64'(ir_valid), 64'((q.size() > 0) || byp));
        chk("ir_out", 64'(ir_out), 64'(exp_out));
        acc = iv && (q.size() < DEPTH);
        if (fl) begin
            q.delete();
        end else if (byp) begin
            if (!rdy) q.push_back(d);
        end else begin
            if ((q.size() > 0) && rdy) void'(q.pop_front());
            if (acc) q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b0;
        ins         = '0;
        ins_valid   = 1'b0;
        flush       = 1'b0;
        ir_ready    = 1'b0;
        w_ins       = '0;
        w_ins_valid = 1'b0;
        w_ir_ready  = 1'b0;

        #2;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_ir_valid", 64'(ir_valid), 64'(0));
        chk("rst_ir_out", 64'(ir_out), 64'h0000);
        chk("rst_ins_ready", 64'(ins_ready), 64'(1));
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;

        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);

        // Fill with decode stalled; fifth offer must be refused
        cycle(1'b1, 16'h1111, 1'b0, 1'b0);
        cycle(1'b1, 16'h2222, 1'b0, 1'b0);
        cycle(1'b1, 16'h3333, 1'b0, 1'b0);
        cycle(1'b1, 16'h4444, 1'b0, 1'b0);
        chk("full_count", 64'(count), 64'(4));
        chk("full_ins_ready", 64'(ins_ready), 64'(0));
        cycle(1'b1, 16'h5555, 1'b0, 1'b0);
        chk("full_head", 64'(ir_out), 64'h1111);
        chk("full_count2", 64'(count), 64'(4));

        // Sustained push+pop from full across pointer wrap
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 16'h6000 + 16'(i), 1'b1, 1'b0);
        end
        chk("stream_count", 64'(count), 64'(3));

        // Flush with concurrent push and pop
        cycle(1'b1, 16'hAAAA, 1'b1, 1'b1);
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_ir_valid", 64'(ir_valid), 64'(0));
        chk("flush_ir_out", 64'(ir_out), 64'h0000);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);

        // Empty queue, fetch and decode both ready
        ins_valid = 1'b1;
        ins       = 16'hBEEF;
        ir_ready  = 1'b1;
        #1;
`ifdef IR_QUEUE_BYPASS_EN
        chk("bypass_same_out", 64'(ir_out), 64'hBEEF);
        chk("bypass_same_valid", 64'(ir_valid), 64'(1));
`else
        chk("nobypass_same_out", 64'(ir_out), 64'h0000);
        chk("nobypass_same_valid", 64'(ir_valid), 64'(0));
`endif
        cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
`ifdef IR_QUEUE_BYPASS_EN
        chk("bypass_next_count", 64'(count), 64'(0));
`else
        chk("nobypass_next_count", 64'(count), 64'(1));
        chk("nobypass_next_out", 64'(ir_out), 64'hBEEF);
`endif
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);

        // Asynchronous reset with three entries held
        cycle(1'b1, 16'h0A01, 1'b0, 1'b0);
        cycle(1'b1, 16'h0A02, 1'b0, 1'b0);
        cycle(1'b1, 16'h0A03, 1'b0, 1'b0);
        chk("pre_rst_count", 64'(count), 64'(3));
        ins_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'(0));
        chk("arst_ir_valid", 64'(ir_valid), 64'(0));
        chk("arst_ir_out", 64'(ir_out), 64'h0000);
        chk("arst_ins_ready", 64'(ins_ready), 64'(1));
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0);
        end
        cycle(1'b0, 16'h0000, 1'b0, 1'b1);

        // WIDTH=32, DEPTH=8 instance: fill, then drain in order
        w_ir_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            w_ins_valid = 1'b1;
            w_ins       = 32'hC0DE_0000 + 32'(i);
            cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        end
        chk("w_full_count", 64'(w_count), 64'(8));
        chk("w_full_ins_ready", 64'(w_ins_ready), 64'(0));
        w_ins_valid = 1'b0;
        w_ir_ready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("w_drain_valid", 64'(w_ir_valid), 64'(1));
            chk("w_drain_out", 64'(w_ir_out), 64'(32'hC0DE_0000 + 32'(i)));
            cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        end
        chk("w_empty_count", 64'(w_count), 64'(0));
        chk("w_empty_valid", 64'(w_ir_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction register/queue. It is the next generation of the single-entry instruction register and sits between instruction memory and the decoder. It buffers up to DEPTH fetched instructions with valid/ready handshakes on both sides, and supports a flush for branches. The head entry is presented to decode and held until decode accepts it.

## Interface
- WIDTH, 16, instruction width in bits
- DEPTH, 4, queue entries; power of two, 2 to 16
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- ins  in  WIDTH  fetched instruction
- ins_valid  in  1  fetch side offers `ins` this cycle
- ins_ready  out  1  queue can accept (= not full)
- flush  in  1  discard all entries (branch/redirect)
- ir_out  out  WIDTH  head instruction to decoder
- ir_valid  out  1  `ir_out` holds a valid instruction
- ir_ready  in  1  decoder consumes head this cycle
- count  out  $clog2(DEPTH+1)  entries currently held

## Operation
- Push on rising edge when `ins_valid && ins_ready && !flush`. Data is written at the write pointer, and the write pointer increments.
- Pop on rising edge when `ir_valid && ir_ready && !flush`. The read pointer increments.
- Push and pop in the same cycle: both happen and `count` is unchanged.
  - This is legal when empty only with the bypass feature (see Configuration).
  - When full, push is blocked because `ins_ready` is low.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Full/empty come from `count` (0 = empty, DEPTH = full).
- `flush` has priority over everything:
  - next cycle `count` = 0 and both pointers are 0;
  - any same-cycle push or pop is discarded.
- `ir_out` shows the head entry while `ir_valid` is high. It is forced to all-zeros when the queue is empty.
- The head remains stable while `ir_valid && !ir_ready`.
- `ins_ready` depends only on registered `count`, with no combinational path from `ir_ready`.
- Memory contents are not reset. Only pointers and `count` are reset.

## Timing
- Reset (`rst` low, asynchronous) gives:
  - `count` = 0, `ir_valid` = 0, `ir_out` = 0, `ins_ready` = 1;
  - pointers = 0.
- Reset asserted mid-operation drops all entries immediately, with no waiting for `clk`.
- Latency without bypass: an instruction pushed at edge N is visible on `ir_out` with `ir_valid` = 1 after edge N.
- Throughput: one push and one pop per cycle, sustained.
- `ins_ready` falls in the cycle after the push that makes `count` = DEPTH.
- `ins_ready` rises in the cycle after a pop from full.
- `flush` takes effect at the edge where it is sampled high. `ir_valid` is 0 in the following cycle.

## Configuration
- Macro: `IR_QUEUE_BYPASS_EN`.
- Defined: when `count` = 0 and `ins_valid` is high (and `flush` is low):
  - `ir_out` = `ins` and `ir_valid` = 1 combinationally;
  - if `ir_ready` is also high, the instruction is consumed without being stored, and `count` stays 0;
  - if `ir_ready` is low, it is stored as a normal push.
- Not defined: no combinational path from `ins` to `ir_out`. Minimum latency is one cycle, and `ir_valid` depends only on registered state.

## Structure
- Shared package `ir_pkg`:
  - default WIDTH/DEPTH localparams;
  - the NOP/reset instruction constant (all-zeros);
  - a function for the count width.
- One sub-module, `ir_queue_mem`: a DEPTH×WIDTH register array with one write port (clocked) and one asynchronous read port, and no reset.
- Pointer/count control and bypass muxing live in `ir_queue`.

## Test plan
- Reset, then idle:
  - expect `count` = 0, `ir_valid` = 0, `ir_out` = 16'h0000, `ins_ready` = 1.
  - Assert `rst` low mid-stream with 3 entries: all outputs return to these values before the next edge.
- Push 16'h1111, 16'h2222, 16'h3333, 16'h4444 with `ir_ready` = 0:
  - `count` reaches 4 and `ins_ready` = 0;
  - a 5th `ins_valid` of 16'h5555 is ignored;
  - `ir_out` stays 16'h1111.
- From full, hold `ir_ready` = 1 and `ins_valid` = 1 for 8 cycles with incrementing data:
  - `count` stays constant after the first pop;
  - the output order is 1111, 2222, 3333, 4444, then the new data;
  - pointers wrap with no loss.
- With 3 entries, assert `flush` together with `ins_valid` (16'hAAAA) and `ir_ready`:
  - next cycle `count` = 0, `ir_valid` = 0;
  - 16'hAAAA never appears.
- Empty queue, `ins_valid` with 16'hBEEF and `ir_ready` = 1:
  - with `IR_QUEUE_BYPASS_EN`: `ir_out` = 16'hBEEF in the same cycle and `count` stays 0;
  - without it: visible next cycle with `count` = 1.
- WIDTH = 32, DEPTH = 8 build: fill to 8, drain, and check ordering and that `count` reaches 4'd8.
